// File: rtl/mem_load_pkg.sv
// Shared types, field widths and address encoders for the memory load driver.
package mem_load_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    PRESENT,
    DONE
  } state_t;

  localparam int X_W            = 7;
  localparam int Y_W            = 7;
  localparam int INCH_W         = 1;
  localparam int K_W            = 2;
  localparam int OUTCH_W        = 4;
  localparam int KERNEL_SEL_BIT = 15;

  // Counter geometry: four nested dimensions, index 0 innermost, wide enough for x/y.
  localparam int NUM_DIMS = 4;
  localparam int CNT_W    = 7;

  function automatic logic [15:0] encode_input(input logic [INCH_W-1:0] inch,
                                               input logic [Y_W-1:0]    y,
                                               input logic [X_W-1:0]    x);
    return {1'b0, inch, y, x};
  endfunction

  // Kernel fields sit right-aligned below the kernel select bit; the gap is zero.
  function automatic logic [15:0] encode_kernel(input logic [INCH_W-1:0]  inch,
                                                input logic [K_W-1:0]     ky,
                                                input logic [K_W-1:0]     kx,
                                                input logic [OUTCH_W-1:0] outch);
    logic [15:0] addr;
    addr = {6'b0, 1'b0, inch, ky, kx, outch};
    addr[KERNEL_SEL_BIT] = 1'b1;
    return addr;
  endfunction

endpackage

// File: rtl/mem_load_driver_if.sv
// Address/data write handshake between the load driver and the chip's memories.
interface mem_load_driver_if;

  logic [15:0] a_input;
  logic        a_valid;
  logic        a_ready;
  logic [15:0] b_input;
  logic        b_valid;
  logic        b_ready;
  logic        int_mem_we;

  modport master (
    output a_input, a_valid, b_input, b_valid, int_mem_we,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_input, a_valid, b_input, b_valid, int_mem_we,
    output a_ready, b_ready
  );

endinterface

// File: rtl/mem_load_counter.sv
// Nested multi-dimension counter; each dimension wraps at its limit and carries outward.
module mem_load_counter
  import mem_load_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           advance,
  input  logic [NUM_DIMS-1:0][CNT_W-1:0] limit,
  output logic [NUM_DIMS-1:0][CNT_W-1:0] count,
  output logic                           last
);

  logic [NUM_DIMS-1:0] at_limit;
  logic [NUM_DIMS:0]   carry;

  always_comb begin
    carry[0] = 1'b1;
    for (int i = 0; i < NUM_DIMS; i++) begin
      at_limit[i]  = (count[i] == limit[i]);
      carry[i + 1] = carry[i] & at_limit[i];
    end
  end

  assign last = &at_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (advance) begin
      for (int i = 0; i < NUM_DIMS; i++) begin
        if (carry[i]) begin
          count[i] <= at_limit[i] ? '0 : count[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_load_driver.sv
// Streams host source words into the chip's input/kernel memories over the a/b handshake.
// Optional build macro MEM_LOAD_CHECKSUM_EN adds a running 16-bit sum of transferred data.
module mem_load_driver
  import mem_load_pkg::*;
#(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int FEATURE_MAP_WIDTH  = 128,
  parameter int FEATURE_MAP_HEIGHT = 128,
  parameter int INPUT_NB_CHANNELS  = 2,
  parameter int OUTPUT_NB_CHANNELS = 16,
  parameter int KERNEL_SIZE        = 3,
  parameter int SRC_ADDR_WIDTH     = 20
) (
  input  logic                      clk,
  input  logic                      arst_n_in,
  input  logic                      start,
  output logic                      busy,
  output logic                      src_read_en,
  output logic [SRC_ADDR_WIDTH-1:0] src_read_addr,
  input  logic [IO_DATA_WIDTH-1:0]  src_qout,
  mem_load_driver_if.master         bus,
  output logic                      data_ready
`ifdef MEM_LOAD_CHECKSUM_EN
  ,
  output logic [15:0]               checksum
`endif
);

  state_t state_q, state_d;

  logic [SRC_ADDR_WIDTH-1:0]     ptr_q;
  logic                          kernel_q;
  logic [15:0]                   a_q;
  logic [15:0]                   b_q;
  logic                          valid_q;
  logic                          data_ready_q;
  logic                          xfer;
  logic                          clear_cnt;
  logic                          adv_cnt;
  logic                          cnt_last;
  logic [NUM_DIMS-1:0][CNT_W-1:0] limit;
  logic [NUM_DIMS-1:0][CNT_W-1:0] cnt;
  logic                          unused_cnt_bits;

  // Input phase walks inch/y/x; kernel phase walks inch/ky/kx/outch (outermost first).
  assign limit = kernel_q
    ? {CNT_W'(INPUT_NB_CHANNELS - 1), CNT_W'(KERNEL_SIZE - 1),
       CNT_W'(KERNEL_SIZE - 1),       CNT_W'(OUTPUT_NB_CHANNELS - 1)}
    : {CNT_W'(0),                     CNT_W'(INPUT_NB_CHANNELS - 1),
       CNT_W'(FEATURE_MAP_HEIGHT - 1), CNT_W'(FEATURE_MAP_WIDTH - 1)};

  assign unused_cnt_bits = ^{cnt[3][CNT_W-1:1], cnt[2][CNT_W-1:2]};

  mem_load_counter u_counter (
    .clk     (clk),
    .rst_n   (arst_n_in),
    .clear   (clear_cnt),
    .advance (adv_cnt),
    .limit   (limit),
    .count   (cnt),
    .last    (cnt_last)
  );

  assign xfer = (state_q == PRESENT) & valid_q & bus.a_ready & bus.b_ready;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_cnt   = 1'b0;
    adv_cnt     = 1'b0;
    src_read_en = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = FETCH;
          clear_cnt = 1'b1;
        end
      end
      FETCH: begin
        src_read_en = 1'b1;
        state_d     = CAPTURE;
      end
      CAPTURE: state_d = PRESENT;
      PRESENT: begin
        if (xfer) begin
          if (cnt_last && kernel_q) begin
            state_d = DONE;
          end else if (cnt_last) begin
            state_d   = FETCH;
            clear_cnt = 1'b1;
          end else begin
            state_d = FETCH;
            adv_cnt = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Word registers, source pointer, phase flag and completion flag.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      ptr_q        <= '0;
      kernel_q     <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      valid_q      <= 1'b0;
      data_ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            ptr_q        <= '0;
            kernel_q     <= 1'b0;
            data_ready_q <= 1'b0;
          end
        end
        CAPTURE: begin
          a_q     <= kernel_q
                     ? encode_kernel(cnt[3][0], cnt[2][1:0], cnt[1][1:0], cnt[0][3:0])
                     : encode_input(cnt[2][0], cnt[1], cnt[0]);
          b_q     <= 16'(src_qout);
          valid_q <= 1'b1;
        end
        PRESENT: begin
          if (xfer) begin
            valid_q <= 1'b0;
            ptr_q   <= ptr_q + 1'b1;
            if (cnt_last && kernel_q) begin
              data_ready_q <= 1'b1;
            end else if (cnt_last) begin
              kernel_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_LOAD_CHECKSUM_EN
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      checksum <= '0;
    end else if ((state_q == IDLE || state_q == DONE) && start) begin
      checksum <= '0;
    end else if (xfer) begin
      checksum <= checksum + b_q;
    end
  end
`endif

  assign busy           = (state_q == FETCH) || (state_q == CAPTURE) || (state_q == PRESENT);
  assign src_read_addr  = ptr_q;
  assign data_ready     = data_ready_q;
  assign bus.a_input    = a_q;
  assign bus.b_input    = b_q;
  assign bus.a_valid    = valid_q;
  assign bus.b_valid    = valid_q;
  assign bus.int_mem_we = xfer;

endmodule

// File: tb/tb_mem_load_driver.sv
// Directed self-checking bench for mem_load_driver on a 4x4x2 map with 2x3x3 kernels.
module tb_mem_load_driver;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int IC = 2;
  localparam int OC = 2;
  localparam int K  = 3;
  localparam int AW = 20;

  logic          clk       = 1'b0;
  logic          arst_n_in = 1'b0;
  logic          start     = 1'b0;
  logic          busy;
  logic          src_read_en;
  logic [AW-1:0] src_read_addr;
  logic [15:0]   src_qout  = '0;
  logic          data_ready;
`ifdef MEM_LOAD_CHECKSUM_EN
  logic [15:0]   checksum;
`endif

  int tests = 0;
  int fails = 0;
  int xfers = 0;
  int cyc   = 0;
  int base;
  int n;
  logic [15:0] log_a [0:255];
  logic [15:0] log_b [0:255];
  int          log_cyc [0:255];

  mem_load_driver_if bus ();

  mem_load_driver #(
    .IO_DATA_WIDTH      (16),
    .FEATURE_MAP_WIDTH  (W),
    .FEATURE_MAP_HEIGHT (H),
    .INPUT_NB_CHANNELS  (IC),
    .OUTPUT_NB_CHANNELS (OC),
    .KERNEL_SIZE        (K),
    .SRC_ADDR_WIDTH     (AW)
  ) dut (
    .clk           (clk),
    .arst_n_in     (arst_n_in),
    .start         (start),
    .busy          (busy),
    .src_read_en   (src_read_en),
    .src_read_addr (src_read_addr),
    .src_qout      (src_qout),
    .bus           (bus),
    .data_ready    (data_ready)
`ifdef MEM_LOAD_CHECKSUM_EN
    ,
    .checksum      (checksum)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Source memory holding word n at address n, one-cycle read latency.
  always @(posedge clk) begin
    if (src_read_en) src_qout <= src_read_addr[15:0];
  end

  always @(negedge clk) begin
    if (bus.int_mem_we) begin
      if (xfers < 256) begin
        log_a[xfers]   = bus.a_input;
        log_b[xfers]   = bus.b_input;
        log_cyc[xfers] = cyc;
      end
      xfers++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic ar, input logic br);
    start       = s;
    bus.a_ready = ar;
    bus.b_ready = br;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"},   32'(busy),           0);
    checkOutput({tag, "_sre"},    32'(src_read_en),    0);
    checkOutput({tag, "_sra"},    32'(src_read_addr),  0);
    checkOutput({tag, "_av"},     32'(bus.a_valid),    0);
    checkOutput({tag, "_bv"},     32'(bus.b_valid),    0);
    checkOutput({tag, "_a"},      32'(bus.a_input),    0);
    checkOutput({tag, "_b"},      32'(bus.b_input),    0);
    checkOutput({tag, "_we"},     32'(bus.int_mem_we), 0);
    checkOutput({tag, "_dr"},     32'(data_ready),     0);
  endtask

  initial begin
    applyStimulus(0, 1, 1);
    repeat (2) tick();
    checkAllZero("reset");
    arst_n_in = 1'b1;
    tick();

    // First full load with readiness tied high.
    applyStimulus(1, 1, 1);
    tick();
    applyStimulus(0, 1, 1);
    checkOutput("lat_sre", 32'(src_read_en), 1);
    checkOutput("lat_sra", 32'(src_read_addr), 0);
    checkOutput("lat_busy", 32'(busy), 1);
    tick();
    checkOutput("lat_av_early", 32'(bus.a_valid), 0);
    tick();
    checkOutput("lat_av", 32'(bus.a_valid), 1);
    checkOutput("lat_bv", 32'(bus.b_valid), 1);

    repeat (10) tick();
    applyStimulus(1, 1, 1);
    tick();
    applyStimulus(0, 1, 1);

    n = 0;
    while (!data_ready && n < 2000) begin
      tick();
      n++;
    end
    checkOutput("done_reached", 32'(data_ready), 1);
    checkOutput("load1_count", 32'(xfers), 68);
    checkOutput("x0_a", 32'(log_a[0]), 32'h0000);
    checkOutput("x0_b", 32'(log_b[0]), 0);
    checkOutput("x4_a", 32'(log_a[4]), 32'h0080);
    checkOutput("x4_b", 32'(log_b[4]), 4);
    checkOutput("x31_a", 32'(log_a[31]), 32'h4183);
    checkOutput("x32_a", 32'(log_a[32]), 32'h8000);
    checkOutput("x32_b", 32'(log_b[32]), 32);
    checkOutput("x65_a", 32'(log_a[65]), 32'h8191);
    checkOutput("x65_b", 32'(log_b[65]), 65);
    checkOutput("x67_a", 32'(log_a[67]), 32'h81A1);
    checkOutput("spacing_0", 32'(log_cyc[1] - log_cyc[0]), 3);
    checkOutput("spacing_32", 32'(log_cyc[32] - log_cyc[31]), 3);
    checkOutput("done_busy", 32'(busy), 0);
`ifdef MEM_LOAD_CHECKSUM_EN
    checkOutput("checksum", 32'(checksum), 2278);
`endif
    repeat (4) tick();
    checkOutput("done_hold", 32'(data_ready), 1);
    checkOutput("done_no_extra", 32'(xfers), 68);

    // Restart from DONE, then stall the sixth word on b_ready.
    base = xfers;
    applyStimulus(1, 1, 1);
    tick();
    applyStimulus(0, 1, 1);
    checkOutput("restart_dr", 32'(data_ready), 0);
    checkOutput("restart_busy", 32'(busy), 1);
    n = 0;
    while (xfers < base + 5 && n < 100) begin
      tick();
      n++;
    end
    checkOutput("bp_reach", 32'(xfers - base), 5);
    applyStimulus(0, 1, 0);
    n = 0;
    while (!bus.a_valid && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_we", 32'(bus.int_mem_we), 0);
      checkOutput("bp_av", 32'(bus.a_valid), 1);
      checkOutput("bp_a", 32'(bus.a_input), 32'h0081);
      checkOutput("bp_b", 32'(bus.b_input), 5);
      tick();
    end
    checkOutput("bp_count", 32'(xfers - base), 5);
    applyStimulus(0, 1, 1);
    #1;
    checkOutput("bp_release_we", 32'(bus.int_mem_we), 1);
    tick();
    checkOutput("bp_pulse_end", 32'(bus.int_mem_we), 0);
    checkOutput("bp_single", 32'(xfers - base), 6);

    // Reset while the tenth word of this load is on the bus.
    n = 0;
    while (!(bus.a_valid && xfers == base + 9) && n < 100) begin
      tick();
      n++;
    end
    checkOutput("x10_live", 32'(bus.int_mem_we), 1);
    arst_n_in = 1'b0;
    #1;
    checkAllZero("midreset");
    repeat (2) tick();
    arst_n_in = 1'b1;
    tick();
    base = xfers;
    applyStimulus(1, 1, 1);
    tick();
    applyStimulus(0, 1, 1);
    n = 0;
    while (xfers == base && n < 50) begin
      tick();
      n++;
    end
    checkOutput("reload_seen", 32'(xfers - base), 1);
    checkOutput("reload_a", 32'(log_a[base]), 32'h0000);
    checkOutput("reload_b", 32'(log_b[base]), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
